// File: rtl/sc_div_pkg.sv
// Shared definitions for the stochastic divide sequencer.
//   state_t      : controller FSM states
//   DEF_WIDTH    : default operand/quotient/LFSR width
//   DEF_LEN_LOG2 : default log2 of the measured stream length
//   lfsr_taps()  : Galois (right-shift) feedback mask for a maximal-length LFSR
package sc_div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WARM = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_LEN_LOG2 = 10;

  // Feedback masks for right-shifting Galois LFSRs, all maximal length.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      12:      lfsr_taps = 32'h0000_0E08;
      16:      lfsr_taps = 32'h0000_B400;
      default: lfsr_taps = 32'h0000_00B8;
    endcase
  endfunction

endpackage

// File: rtl/sc_lfsr_sng.sv
// Stochastic number generator: Galois LFSR plus magnitude comparator.
//   clk, reset : clock, synchronous active-high reset (reloads seed)
//   load       : reload the LFSR with seed
//   step       : advance the LFSR one state
//   seed       : reload value, must be nonzero
//   value      : binary magnitude being converted to a stream
//   stream_bit : 1 when value > current LFSR state
// The output cannot be called "bit" because that is a reserved word.
module sc_lfsr_sng
  import sc_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] value,
  output logic             stream_bit
);

  localparam logic [31:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] lfsr_reg;
  logic [WIDTH-1:0] lfsr_next;

  always_comb begin
    lfsr_next = lfsr_reg;
    if (load) begin
      lfsr_next = seed;
    end else if (step) begin
      lfsr_next = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_reg <= seed;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign stream_bit = (value > lfsr_reg);

endmodule

// File: rtl/sc_div_sequencer.sv
// Stochastic divider controller: accepts num/den, runs two LFSR streams into
// a JK divider cell, counts its ones over 2^LEN_LOG2 cycles after a warm-up
// and returns floor(2^WIDTH * num/(num+den)) (saturated) as a binary value.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : request handshake carrying num, den
//   out_valid/out_ready  : result handshake carrying quotient, err
//   err                  : request had num == den == 0
//   busy                 : high in LOAD/WARM/RUN
module sc_div_sequencer
  import sc_div_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               LEN_LOG2 = DEF_LEN_LOG2,
  parameter int               WARMUP   = 16,
  parameter logic [WIDTH-1:0] SEED_A   = WIDTH'(8'hA5),
  parameter logic [WIDTH-1:0] SEED_B   = WIDTH'(8'h3C)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             err,
  output logic             busy
);

  // One counter serves both WARM and RUN, so size it for the longer phase.
  localparam int CNT_W = (WARMUP > (1 << LEN_LOG2)) ? $clog2(WARMUP + 1) : LEN_LOG2 + 1;
  localparam logic [CNT_W-1:0] WARM_LAST = (WARMUP > 0) ? CNT_W'(WARMUP - 1) : '0;
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'((1 << LEN_LOG2) - 1);

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    num_reg, num_next;
  logic [WIDTH-1:0]    den_reg, den_next;
  logic                jk_q_reg, jk_q_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [LEN_LOG2:0]   ones_reg, ones_next;
  logic [WIDTH-1:0]    quotient_reg, quotient_next;
  logic                err_reg, err_next;

  logic                lfsr_load;
  logic                lfsr_step;
  logic [1:0]          stream_bits;   // [0] = a (num), [1] = b (den)
  logic                jk_new;

  for (genvar gi = 0; gi < 2; gi++) begin : g_sng
    sc_lfsr_sng #(
      .WIDTH(WIDTH)
    ) u_sng (
      .clk       (clk),
      .reset     (reset),
      .load      (lfsr_load),
      .step      (lfsr_step),
      .seed      ((gi == 0) ? SEED_A : SEED_B),
      .value     ((gi == 0) ? num_reg : den_reg),
      .stream_bit(stream_bits[gi])
    );
  end

  // JK cell: a sets, b clears, both toggle, neither holds.
  always_comb begin
    jk_new = jk_q_reg;
    case ({stream_bits[0], stream_bits[1]})
      2'b01:   jk_new = 1'b0;
      2'b10:   jk_new = 1'b1;
      2'b11:   jk_new = ~jk_q_reg;
      default: jk_new = jk_q_reg;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    num_next      = num_reg;
    den_next      = den_reg;
    jk_q_next     = jk_q_reg;
    cnt_next      = cnt_reg;
    ones_next     = ones_reg;
    quotient_next = quotient_reg;
    err_next      = err_reg;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          num_next = num;
          den_next = den;
          if ((num == '0) && (den == '0)) begin
            quotient_next = '0;
            err_next      = 1'b1;
            state_next    = DONE;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        lfsr_load  = 1'b1;
        jk_q_next  = 1'b0;
        cnt_next   = '0;
        ones_next  = '0;
        state_next = (WARMUP == 0) ? RUN : WARM;
      end
      WARM: begin
        lfsr_step = 1'b1;
        jk_q_next = jk_new;
        if (cnt_reg == WARM_LAST) begin
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RUN: begin
        lfsr_step = 1'b1;
        jk_q_next = jk_new;
        ones_next = ones_reg + {{LEN_LOG2{1'b0}}, jk_q_reg};
        if (cnt_reg == RUN_LAST) begin
          cnt_next = '0;
          // Result uses the count including this final cycle; a full count
          // (every cycle one) would overflow WIDTH bits, so saturate it.
          quotient_next = ones_next[LEN_LOG2] ? '1 : ones_next[LEN_LOG2-1 -: WIDTH];
          err_next      = 1'b0;
          state_next    = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      num_reg      <= '0;
      den_reg      <= '0;
      jk_q_reg     <= 1'b0;
      cnt_reg      <= '0;
      ones_reg     <= '0;
      quotient_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      num_reg      <= num_next;
      den_reg      <= den_next;
      jk_q_reg     <= jk_q_next;
      cnt_reg      <= cnt_next;
      ones_reg     <= ones_next;
      quotient_reg <= quotient_next;
      err_reg      <= err_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == LOAD) || (state_reg == WARM) || (state_reg == RUN);
  assign quotient  = quotient_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_sc_div_sequencer.sv
// Directed bench for sc_div_sequencer with default parameters.
module tb_sc_div_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] num = '0;
  logic [7:0] den = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic       err;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q_first;

  localparam int NORMAL_LAT = 1 + 16 + 1024 + 1;

  always #5 clk = ~clk;

  sc_div_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .num      (num),
    .den      (den),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .err      (err),
    .busy     (busy)
  );

  // Called #1 after an edge with the DUT in IDLE. lat counts edges from the
  // accept edge (inclusive) until out_valid is seen; 5000 on timeout.
  task automatic run_req(input logic [7:0] n, input logic [7:0] d, input bit take,
                         output int lat, output logic [7:0] q, output logic e);
    in_valid = 1'b1; num = n; den = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quotient; e = err;
    if (take) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    $display("req num=%0d den=%0d -> quotient=%0d err=%0b latency=%0d", n, d, q, e, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    vectors++;
    if ({in_ready, out_valid, quotient, err, busy} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b quotient=%0d err=%b busy=%b, want 1 0 0 0 0",
               in_ready, out_valid, quotient, err, busy);
    end
  endtask

  task automatic test_half();
    int lat; logic [7:0] q; logic e;
    run_req(8'd128, 8'd128, 1'b1, lat, q, e);
    q_first = q;
    vectors++;
    if (lat !== NORMAL_LAT) begin
      miscompares++; $display("FAIL half_latency: got %0d want %0d", lat, NORMAL_LAT);
    end
    vectors++;
    if (q < 8'd113 || q > 8'd143) begin
      miscompares++; $display("FAIL half_quotient: got %0d want 113..143", q);
    end
    vectors++;
    if (e !== 1'b0) begin
      miscompares++; $display("FAIL half_err: got %b want 0", e);
    end
  endtask

  task automatic test_ratio_backpressure();
    int lat; logic [7:0] q; logic e; bit bad;
    run_req(8'd192, 8'd64, 1'b0, lat, q, e);
    vectors++;
    if (q < 8'd177 || q > 8'd207) begin
      miscompares++; $display("FAIL ratio_192_64: got %0d want 177..207", q);
    end
    // Hold the result with a pending new request on the input side.
    in_valid = 1'b1; num = 8'd64; den = 8'd192;
    bad = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || quotient !== q || err !== e || in_ready !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL backpressure_hold: got out_valid=%b quotient=%0d err=%b in_ready=%b, want 1 %0d %b 0",
               out_valid, quotient, err, in_ready, q, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;   // accept edge for the held request
    in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL new_request_accept: got busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    lat = 1;
    while (!out_valid && lat < 5000) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quotient;
    $display("req num=64 den=192 -> quotient=%0d err=%0b latency=%0d", q, err, lat);
    vectors++;
    if (lat !== NORMAL_LAT || q < 8'd49 || q > 8'd79) begin
      miscompares++; $display("FAIL ratio_64_192: got quotient=%0d latency=%0d want 49..79 latency %0d", q, lat, NORMAL_LAT);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_boundaries();
    int lat; logic [7:0] q; logic e;
    run_req(8'd200, 8'd0, 1'b1, lat, q, e);
    vectors++;
    if (q < 8'd250 || e !== 1'b0) begin
      miscompares++; $display("FAIL den_zero: got quotient=%0d err=%b want >=250 err 0", q, e);
    end
    run_req(8'd0, 8'd200, 1'b1, lat, q, e);
    vectors++;
    if (q !== 8'd0 || e !== 1'b0) begin
      miscompares++; $display("FAIL num_zero: got quotient=%0d err=%b want 0 err 0", q, e);
    end
  endtask

  task automatic test_err();
    int lat; logic [7:0] q; logic e;
    run_req(8'd0, 8'd0, 1'b0, lat, q, e);
    vectors++;
    if (lat !== 1) begin
      miscompares++; $display("FAIL err_latency: got %0d want 1", lat);
    end
    vectors++;
    if (q !== 8'd0 || e !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL err_result: got quotient=%0d err=%b in_ready=%b want 0 1 0", q, e, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lat; logic [7:0] q; logic e; bit saw_valid;
    in_valid = 1'b1; num = 8'd128; den = 8'd128;
    @(posedge clk); #1;
    in_valid = 1'b0;
    saw_valid = 1'b0;
    repeat (517) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL abort_running: got busy=%b want 1", busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    if (out_valid) saw_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || saw_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got in_ready=%b busy=%b saw_out_valid=%b want 1 0 0", in_ready, busy, saw_valid);
    end
    run_req(8'd128, 8'd128, 1'b1, lat, q, e);
    vectors++;
    if (q !== q_first || lat !== NORMAL_LAT) begin
      miscompares++;
      $display("FAIL abort_rerun: got quotient=%0d latency=%0d want %0d latency %0d", q, lat, q_first, NORMAL_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_half();
    test_ratio_backpressure();
    test_boundaries();
    test_err();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
